test_monitor: RTL and testbench

TEST_MONITOR -- requirements
Module: test_monitor

---
 rtl/test_monitor.sv | 85 ++++++++
 tb/tb_test_monitor.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/test_monitor.sv
// test_monitor: watches CPU bus writes against per-channel address/data signatures
// and reports PASS, FAIL or TIMEOUT for each armed check run.
module test_monitor #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8,
    parameter int NCHK   = 4,
    parameter int CNT_W  = 16
) (
    input  logic                   ph0,
    input  logic                   resetb,
    input  logic                   start,
    input  logic [ADDR_W-1:0]      address,
    input  logic [DATA_W-1:0]      data_out,
    input  logic                   read_en,
    input  logic [NCHK*ADDR_W-1:0] chk_addr,
    input  logic [NCHK*DATA_W-1:0] chk_data,
    input  logic [NCHK-1:0]        chk_en,
    input  logic [CNT_W-1:0]       timeout,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [NCHK-1:0]        hit_mask,
    output logic [NCHK-1:0]        fail_mask,
    output logic [CNT_W-1:0]       cycles
);
    typedef enum logic [2:0] {ST_IDLE, ST_RUN, ST_PASS, ST_FAIL, ST_TIMEOUT} state_t;

    state_t                   state, nxt;
    logic [NCHK*ADDR_W-1:0]   l_addr;
    logic [NCHK*DATA_W-1:0]   l_data;
    logic [NCHK-1:0]          l_en;
    logic [CNT_W-1:0]         l_to;
    logic [NCHK-1:0]          match, hit_n, fail_n;
    logic [CNT_W-1:0]         cyc_n;

    // Updated masks feed the completion test so a final write finishes on its own edge.
    always_comb begin
        match  = '0;
        fail_n = fail_mask;
        for (int i = 0; i < NCHK; i++) begin
            match[i]  = !read_en && l_en[i] && (address == l_addr[i*ADDR_W +: ADDR_W]);
            fail_n[i] = match[i] ? (data_out != l_data[i*DATA_W +: DATA_W]) : fail_mask[i];
        end
        hit_n = hit_mask | match;
        cyc_n = (cycles == '1) ? cycles : cycles + CNT_W'(1);
        nxt   = ((hit_n & l_en) == l_en) ? ((fail_n == '0) ? ST_PASS : ST_FAIL) :
                ((l_to != '0) && (cyc_n == l_to)) ? ST_TIMEOUT : ST_RUN;
    end

    always_ff @(posedge ph0 or negedge resetb) begin
        if (!resetb) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            hit_mask  <= '0;
            fail_mask <= '0;
            cycles    <= '0;
            l_addr    <= '0;
            l_data    <= '0;
            l_en      <= '0;
            l_to      <= '0;
        end else if (state != ST_RUN && start) begin
            state     <= ST_RUN;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            hit_mask  <= '0;
            fail_mask <= '0;
            cycles    <= '0;
            l_addr    <= chk_addr;
            l_data    <= chk_data;
            l_en      <= chk_en;
            l_to      <= timeout;
        end else if (state == ST_RUN) begin
            state     <= nxt;
            busy      <= nxt == ST_RUN;
            done      <= nxt != ST_RUN;
            pass      <= nxt == ST_PASS;
            hit_mask  <= hit_n;
            fail_mask <= fail_n;
            cycles    <= cyc_n;
        end
    end
endmodule

// File: tb/tb_test_monitor.sv
// tb_test_monitor: directed vectors with hand-computed expectations for test_monitor.
module tb_test_monitor;
    logic        ph0 = 1'b0, resetb = 1'b0, start = 1'b0, read_en = 1'b1;
    logic [15:0] address = '0, timeout = '0;
    logic [7:0]  data_out = '0;
    logic [63:0] chk_addr = '0;
    logic [31:0] chk_data = '0;
    logic [3:0]  chk_en = '0;
    logic        busy, done, pass;
    logic [3:0]  hit_mask, fail_mask;
    logic [15:0] cycles;
    int total = 0, bad = 0;

    test_monitor dut (
        .ph0(ph0), .resetb(resetb), .start(start), .address(address),
        .data_out(data_out), .read_en(read_en), .chk_addr(chk_addr),
        .chk_data(chk_data), .chk_en(chk_en), .timeout(timeout),
        .busy(busy), .done(done), .pass(pass), .hit_mask(hit_mask),
        .fail_mask(fail_mask), .cycles(cycles)
    );

    always #5 ph0 = ~ph0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge ph0);
            #1;
        end
    endtask

    task automatic arm();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d, input logic rd = 1'b0);
        address = a; data_out = d; read_en = rd;
        tick();
        read_en = 1'b1;
    endtask

    task automatic cfg(input int ch, input logic [15:0] a, input logic [7:0] d);
        chk_addr[ch*16 +: 16] = a;
        chk_data[ch*8 +: 8]   = d;
    endtask

    task automatic expect_out(input string tag, input logic b, input logic dn, input logic p,
                              input logic [3:0] h, input logic [3:0] f, input logic [15:0] c);
        check({tag, ".busy"}, busy, b);
        check({tag, ".done"}, done, dn);
        check({tag, ".pass"}, pass, p);
        check({tag, ".hit"}, hit_mask, h);
        check({tag, ".fail"}, fail_mask, f);
        check({tag, ".cycles"}, cycles, c);
    endtask

    initial begin
        #2 expect_out("reset", 0, 0, 0, 4'h0, 4'h0, 16'd0);
        #10 resetb = 1'b1;

        // Basic pass; disabled ch1 shares the address and must stay clear.
        cfg(0, 16'h0042, 8'hCF); cfg(1, 16'h0042, 8'h00);
        chk_en = 4'b0001; timeout = 16'd100;
        arm();
        expect_out("armed", 1, 0, 0, 4'h0, 4'h0, 16'd0);
        cfg(0, 16'h0042, 8'h00); chk_en = 4'b1111; timeout = 16'd3;
        tick(19);
        wr(16'h0042, 8'hCF);
        expect_out("pass1", 0, 1, 1, 4'h1, 4'h0, 16'd20);
        wr(16'h0042, 8'h00); tick(3);
        expect_out("hold", 0, 1, 1, 4'h1, 4'h0, 16'd20);

        // Mismatch -> FAIL, start ignored while running, then re-run passes.
        cfg(0, 16'h0042, 8'hCF); chk_en = 4'b0001; timeout = 16'd100;
        arm(); tick(3);
        arm();
        check("start_in_run.cycles", cycles, 16'd4);
        wr(16'h0042, 8'hCE);
        expect_out("fail1", 0, 1, 0, 4'h1, 4'h1, 16'd5);
        arm();
        wr(16'h0042, 8'hCF);
        expect_out("rerun", 0, 1, 1, 4'h1, 4'h0, 16'd1);

        // Timeout with ch1 never written.
        cfg(1, 16'h0100, 8'h33); chk_en = 4'b0011; timeout = 16'd50;
        arm(); tick(2);
        wr(16'h0042, 8'hCF);
        tick(46);
        expect_out("pre_to", 1, 0, 0, 4'h1, 4'h0, 16'd49);
        tick();
        expect_out("timeout", 0, 1, 0, 4'h1, 4'h0, 16'd50);

        // Watchdog disabled: counter saturates and RUN holds.
        timeout = 16'd0;
        arm();
        tick(65540);
        expect_out("sat", 1, 0, 0, 4'h0, 4'h0, 16'hFFFF);
        wr(16'h0042, 8'hCF); wr(16'h0100, 8'h33);
        expect_out("sat_done", 0, 1, 1, 4'h3, 4'h0, 16'hFFFF);

        // Shared address across ch0 and ch2.
        cfg(0, 16'h0200, 8'h11); cfg(2, 16'h0200, 8'h22);
        chk_en = 4'b0101; timeout = 16'd0;
        arm();
        wr(16'h0200, 8'h11);
        expect_out("shared", 0, 1, 0, 4'h5, 4'h4, 16'd1);

        // No enabled channels: pass on first RUN edge.
        chk_en = 4'b0000;
        arm(); tick();
        expect_out("empty", 0, 1, 1, 4'h0, 4'h0, 16'd1);

        // Read at signature address ignored; completion beats timeout on the same edge.
        cfg(0, 16'h0042, 8'hCF); chk_en = 4'b0001; timeout = 16'd10;
        arm(); tick();
        wr(16'h0042, 8'hCF, 1'b1);
        expect_out("read", 1, 0, 0, 4'h0, 4'h0, 16'd2);
        tick(7);
        wr(16'h0042, 8'hCF);
        expect_out("prio", 0, 1, 1, 4'h1, 4'h0, 16'd10);

        // Async reset mid-run, then a clean run.
        timeout = 16'd100;
        arm(); tick(10);
        resetb = 1'b0;
        #2 expect_out("rst_mid", 0, 0, 0, 4'h0, 4'h0, 16'd0);
        resetb = 1'b1;
        tick(2);
        expect_out("post_rst", 0, 0, 0, 4'h0, 4'h0, 16'd0);
        arm(); tick(4);
        wr(16'h0042, 8'hCF);
        expect_out("after_rst", 0, 1, 1, 4'h1, 4'h0, 16'd5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
